// File: rtl/serial_chunk_adder.sv
// Signed add/subtract over WIDTH bits, CHUNK bits per clock, with valid/ready handshakes.
// Produces sum, carry, the exact WIDTH+1 result and {N,Z,C,V} flags.
module serial_chunk_adder #(
    parameter int WIDTH = 5,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [WIDTH:0]   result,
    output logic [3:0]       flags
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("serial_chunk_adder: illegal WIDTH/CHUNK combination");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_acc;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             sign_a;
    logic             sign_b;

    logic             accept;
    logic             last;
    logic [WIDTH-1:0] b_eff;
    logic [CHUNK:0]   csum;
    logic [WIDTH-1:0] sum_next;
    logic             top_bit;

    assign in_ready = (state == IDLE) || (state == DONE && out_ready);
    assign accept   = in_valid && in_ready;
    assign b_eff    = sub ? ~b : b;
    assign last     = (cnt == CW'(NCHUNK - 1));

    // Operands shift right each cycle; result chunks enter at the top of sum_acc.
    always_comb begin
        csum     = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, b_sh[CHUNK-1:0]} + (CHUNK+1)'(carry);
        sum_next = sum_acc >> CHUNK;
        sum_next[WIDTH-1 -: CHUNK] = csum[CHUNK-1:0];
        // Sign extension of both operands plus the final carry gives the exact top bit.
        top_bit  = sign_a ^ sign_b ^ csum[CHUNK];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            sum_acc   <= '0;
            cnt       <= '0;
            carry     <= 1'b0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else if (accept) begin
            state     <= BUSY;
            a_sh      <= a;
            b_sh      <= b_eff;
            carry     <= sub ? 1'b1 : cin;
            sign_a    <= a[WIDTH-1];
            sign_b    <= b_eff[WIDTH-1];
            sum_acc   <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                BUSY: begin
                    a_sh    <= a_sh >> CHUNK;
                    b_sh    <= b_sh >> CHUNK;
                    carry   <= csum[CHUNK];
                    sum_acc <= sum_next;
                    cnt     <= cnt + CW'(1);
                    if (last) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        sum       <= sum_next;
                        cout      <= csum[CHUNK];
                        result    <= {top_bit, sum_next};
                        flags     <= {sum_next[WIDTH-1], sum_next == '0, csum[CHUNK],
                                      top_bit ^ sum_next[WIDTH-1]};
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_chunk_adder.sv
// Directed bench for serial_chunk_adder: CHUNK=1 and CHUNK=5 instances, WIDTH=5.
module tb_serial_chunk_adder;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
    logic [4:0] a, b, sum;
    logic [5:0] result;
    logic [3:0] flags;
    logic       in_valid5, in_ready5, cin5, sub5, out_valid5, out_ready5, cout5;
    logic [4:0] a5, b5, sum5;
    logic [5:0] result5;
    logic [3:0] flags5;

    int tests = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_chunk_adder #(.WIDTH(5), .CHUNK(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .result(result), .flags(flags)
    );

    serial_chunk_adder #(.WIDTH(5), .CHUNK(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid5), .in_ready(in_ready5),
        .a(a5), .b(b5), .cin(cin5), .sub(sub5), .out_valid(out_valid5), .out_ready(out_ready5),
        .sum(sum5), .cout(cout5), .result(result5), .flags(flags5)
    );

    // Drives one operation into the CHUNK=1 instance and returns edges from accept to out_valid.
    task automatic run_op(input logic [4:0] ta, input logic [4:0] tb, input logic tcin,
                          input logic tsub, output int lat);
        @(negedge clk);
        a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        in_valid5 = 1'b0; out_ready5 = 1'b1; a5 = '0; b5 = '0; cin5 = 1'b0; sub5 = 1'b0;
        #12;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 5'd0 || cout !== 1'b0 ||
            result !== 6'd0 || flags !== 4'd0) begin
            failures++;
            $display("FAIL reset_state: got v=%b rdy=%b sum=%b c=%b res=%b fl=%b, want v=0 rdy=1 all 0",
                     out_valid, in_ready, sum, cout, result, flags);
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_add();
        int lat;
        run_op(5'b01111, 5'b00001, 1'b0, 1'b0, lat);
        tests++;
        if (lat !== 5) begin failures++; $display("FAIL add_latency: got %0d want 5", lat); end
        tests++;
        if ({sum, cout, result, flags} !== {5'b10000, 1'b0, 6'b010000, 4'b1001}) begin
            failures++;
            $display("FAIL add_15_1: got sum=%b c=%b res=%b fl=%b want 10000 0 010000 1001",
                     sum, cout, result, flags);
        end
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL valid_one_cycle: got %b want 0", out_valid); end
    endtask

    task automatic test_carry_zero();
        int lat;
        run_op(5'b11111, 5'b00001, 1'b1, 1'b0, lat);
        tests++;
        if ({sum, cout, result, flags} !== {5'b00001, 1'b1, 6'b000001, 4'b0010}) begin
            failures++;
            $display("FAIL add_m1_1_c: got sum=%b c=%b res=%b fl=%b want 00001 1 000001 0010",
                     sum, cout, result, flags);
        end
        run_op(5'b00011, 5'b11101, 1'b0, 1'b0, lat);
        tests++;
        if ({sum, cout, result, flags} !== {5'b00000, 1'b1, 6'b000000, 4'b0110}) begin
            failures++;
            $display("FAIL add_3_m3: got sum=%b c=%b res=%b fl=%b want 00000 1 000000 0110",
                     sum, cout, result, flags);
        end
    endtask

    task automatic test_overflow();
        int lat;
        run_op(5'b10000, 5'b10000, 1'b0, 1'b0, lat);
        tests++;
        if ({sum, cout, result, flags} !== {5'b00000, 1'b1, 6'b100000, 4'b0111}) begin
            failures++;
            $display("FAIL add_m16_m16: got sum=%b c=%b res=%b fl=%b want 00000 1 100000 0111",
                     sum, cout, result, flags);
        end
        run_op(5'b01010, 5'b01010, 1'b1, 1'b0, lat);
        tests++;
        if ({sum, cout, result, flags} !== {5'b10101, 1'b0, 6'b010101, 4'b1001}) begin
            failures++;
            $display("FAIL add_10_10_c: got sum=%b c=%b res=%b fl=%b want 10101 0 010101 1001",
                     sum, cout, result, flags);
        end
    endtask

    task automatic test_sub();
        int lat;
        run_op(5'b00111, 5'b01000, 1'b1, 1'b1, lat);
        tests++;
        if ({sum, cout, result, flags} !== {5'b11111, 1'b0, 6'b111111, 4'b1000}) begin
            failures++;
            $display("FAIL sub_7_8: got sum=%b c=%b res=%b fl=%b want 11111 0 111111 1000",
                     sum, cout, result, flags);
        end
    endtask

    task automatic test_chunk5();
        int lat;
        @(negedge clk);
        a5 = 5'b00111; b5 = 5'b01000; cin5 = 1'b1; sub5 = 1'b1; in_valid5 = 1'b1;
        @(posedge clk);
        #1 in_valid5 = 1'b0;
        lat = 0;
        while (!out_valid5 && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        tests++;
        if (lat !== 1) begin failures++; $display("FAIL chunk5_latency: got %0d want 1", lat); end
        tests++;
        if ({sum5, cout5, result5, flags5} !== {5'b11111, 1'b0, 6'b111111, 4'b1000}) begin
            failures++;
            $display("FAIL chunk5_sub_7_8: got sum=%b c=%b res=%b fl=%b want 11111 0 111111 1000",
                     sum5, cout5, result5, flags5);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit bad;
        out_ready = 1'b0;
        run_op(5'b00101, 5'b00010, 1'b0, 1'b0, lat);
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = 5'b00001; b = 5'b00001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
            #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 5'b00111 ||
                result !== 6'b000111 || flags !== 4'b0000) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            failures++;
            $display("FAIL hold_stable: got v=%b rdy=%b sum=%b res=%b fl=%b want 1 0 00111 000111 0000",
                     out_valid, in_ready, sum, result, flags);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL ready_in_done: got %b want 1", in_ready); end
        @(posedge clk);
        #1 in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_valid_drop: got %b want 0", out_valid); end
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        tests++;
        if (lat !== 5) begin failures++; $display("FAIL b2b_latency: got %0d want 5", lat); end
        tests++;
        if ({sum, cout, result, flags} !== {5'b00010, 1'b0, 6'b000010, 4'b0000}) begin
            failures++;
            $display("FAIL b2b_result: got sum=%b c=%b res=%b fl=%b want 00010 0 000010 0000",
                     sum, cout, result, flags);
        end
    endtask

    task automatic test_reset_midflight();
        int lat;
        bit seen;
        @(negedge clk);
        a = 5'b00011; b = 5'b00100; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 5'd0 || cout !== 1'b0 ||
            result !== 6'd0 || flags !== 4'd0) begin
            failures++;
            $display("FAIL midflight_reset: got v=%b rdy=%b sum=%b c=%b res=%b fl=%b want 0 1 all 0",
                     out_valid, in_ready, sum, cout, result, flags);
        end
        @(negedge clk) rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        tests++;
        if (seen) begin failures++; $display("FAIL discarded_op: got out_valid=1 want 0"); end
        run_op(5'b00011, 5'b00100, 1'b0, 1'b0, lat);
        tests++;
        if (lat !== 5 || {sum, cout, result, flags} !== {5'b00111, 1'b0, 6'b000111, 4'b0000}) begin
            failures++;
            $display("FAIL after_reset_op: got lat=%0d sum=%b c=%b res=%b fl=%b want 5 00111 0 000111 0000",
                     lat, sum, cout, result, flags);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_carry_zero();
        test_overflow();
        test_sub();
        test_chunk5();
        test_back_to_back();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule

// File: doc/serial_chunk_adder.md
Name: serial_chunk_adder

Overview:
- Parametrised successor to the 5-bit combinational adder and flag post-processor pair.
- Computes a signed two's-complement add or subtract over WIDTH bits, processing CHUNK bits per clock. Returns sum, carry, the exact WIDTH+1 result and the NZCV flags.
- Uses valid/ready handshakes on both sides. It sits between operand sources and result consumers in the arithmetic datapath.

Parameters:
- WIDTH, 5, operand width in bits. Must be at least 2.
- CHUNK, 1, bits added per cycle. Must satisfy 1 <= CHUNK <= WIDTH and WIDTH % CHUNK == 0; any other value is an elaboration error.
- NCHUNK (localparam), WIDTH/CHUNK, number of compute cycles.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  signed operand A.
- b  input  WIDTH  signed operand B.
- cin  input  1  carry-in. Used only when sub=0.
- sub  input  1  0: a+b+cin; 1: a-b, with cin ignored.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  low WIDTH bits of the result.
- cout  output  1  unsigned carry out of bit WIDTH-1.
- result  output  WIDTH+1  exact signed result; never overflows.
- flags  output  4  {N,Z,C,V}, with bit3=N.

Behaviour:
- Arithmetic:
  - Define B' = sub ? ~b : b and c0 = sub ? 1 : cin.
  - The unsigned sum a + B' + c0 gives {cout, sum}.
  - result = sext(a) ± sext(b) (+cin when add), computed at WIDTH+1 bits.
  - N = sum[WIDTH-1]; Z = (sum == 0); C = cout; V = result[WIDTH] ^ result[WIDTH-1].
- FSM states IDLE, BUSY, DONE:
  - IDLE: in_ready=1. When in_valid=1, register a, B', c0 and sub, clear the chunk counter, and go to BUSY.
  - BUSY: in_ready=0 and in_valid is ignored. Each cycle adds chunk k (bits k*CHUNK..k*CHUNK+CHUNK-1) using the registered carry, and stores the result bits in the internal sum register.
  - BUSY exit: after the cycle that processes chunk NCHUNK-1, go to DONE and load sum, cout, result and flags into the output registers in the same edge.
  - DONE: out_valid=1, and all outputs are held stable until out_ready=1.
  - DONE exit: on out_ready=1, go to IDLE. If in_valid=1 in that same cycle, accept the new operands and go directly to BUSY; in_ready = DONE && out_ready.
- Latency:
  - If operands are accepted at edge t, out_valid rises at edge t+NCHUNK.
  - Sustained throughput is one operation per NCHUNK+1 cycles.
- Output rules:
  - out_valid never drops without out_ready=1.
  - Output registers change only on entry to DONE or on reset.
  - in_ready is decoded combinationally from state and out_ready.
- Reset:
  - When rst_n is low, at any time, the block goes to IDLE immediately and asynchronously.
  - out_valid=0 and sum, cout, result, flags and the internal counter/carry are all cleared to 0.
  - An operation in flight is discarded with no result. in_ready=1 once the state is IDLE.
- Boundary cases:
  - CHUNK=WIDTH gives a single-cycle BUSY.
  - When out_ready is held high, out_valid is high for exactly one cycle per result.

Test Plan:
- WIDTH=5, CHUNK=1, a=01111, b=00001, cin=0, sub=0 -> out_valid 5 cycles after accept; sum=10000, cout=0, result=010000 (16), flags=1001.
- a=11111, b=00001, cin=1 -> sum=00001, cout=1, result=000001, flags=0010. Also a=00011, b=11101, cin=0 -> sum=00000, result=0, flags=0110.
- a=10000, b=10000, cin=0 -> sum=00000, cout=1, result=100000 (-32), flags=0111. Also a=01010, b=01010, cin=1 -> result=010101 (21), flags=1001.
- sub=1, a=00111, b=01000, cin=1 (ignored) -> sum=11111, cout=0, result=111111 (-1), flags=1000. Repeat with CHUNK=5: same values, out_valid 1 cycle after accept.
- Hold out_ready=0 for 3 cycles in DONE, with in_valid=1 and new operands -> outputs stable and in_ready=0. Then out_ready=1 with in_valid=1 -> back-to-back accept in the same cycle, and the second result follows NCHUNK cycles later.
- Assert rst_n=0 at chunk 2 of 5 -> out_valid=0 and all outputs 0 immediately; no result appears after rst_n releases; next operation completes correctly.
